peak_detect: RTL and testbench

PEAK_DETECT -- requirements
Module: peak_detect

---
 rtl/peak_detect_pkg.sv | 18 +
 rtl/peak_detect.sv | 135 +++++++++++++
 tb/tb_peak_detect.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/peak_detect_pkg.sv
// Shared width defaults and counter helpers for the spectral peak detector.
// Width macros may be pre-defined by a shared constants header; these are fallbacks.
`ifndef VALUE_WIDTH
`define VALUE_WIDTH 24
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 10
`endif

package peak_detect_pkg;
  localparam int DATA_WIDTH  = 32;
  localparam int COUNT_WIDTH = 16;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == COUNT_MAX) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/peak_detect.sv
// Per-frame maximum search over a windowed, thresholded power stream.
// One result per frame with a single-entry output register; results that find it full are counted and dropped.
module peak_detect
  import peak_detect_pkg::*;
#(
  parameter int VALUE_WIDTH = `VALUE_WIDTH,
  parameter int INDEX_WIDTH = `INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [DATA_WIDTH-1:0]  s_axis_data_tdata,
  input  logic                   s_axis_data_tvalid,
  input  logic                   s_axis_data_tlast,
  output logic                   s_axis_data_tready,
  input  logic [INDEX_WIDTH-1:0] xk_in,
  input  logic                   enable,
  input  logic [VALUE_WIDTH-1:0] threshold,
  input  logic [INDEX_WIDTH-1:0] min_index,
  input  logic [INDEX_WIDTH-1:0] max_index,
  output logic [DATA_WIDTH-1:0]  m_axis_peak_tdata,
  output logic [INDEX_WIDTH:0]   m_axis_peak_tuser,
  output logic                   m_axis_peak_tvalid,
  input  logic                   m_axis_peak_tready,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [COUNT_WIDTH-1:0] drop_count
);

  typedef enum logic [1:0] {IDLE, SYNC, SCAN} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [VALUE_WIDTH-1:0] r_peak_value;
  logic [INDEX_WIDTH-1:0] r_peak_index;
  logic                   r_found;
  logic [VALUE_WIDTH-1:0] r_out_value;
  logic [INDEX_WIDTH-1:0] r_out_index;
  logic                   r_out_found;
  logic                   r_out_valid;
  logic [COUNT_WIDTH-1:0] r_frame_count;
  logic [COUNT_WIDTH-1:0] r_drop_count;

  logic [VALUE_WIDTH-1:0] w_value;
  logic                   w_scanning;
  logic                   w_scan_beat;
  logic                   w_candidate;
  logic                   w_take;
  logic                   w_frame_done;
  logic                   w_out_free;
  logic [VALUE_WIDTH-1:0] w_res_value;
  logic [INDEX_WIDTH-1:0] w_res_index;
  logic                   w_res_found;

  if (VALUE_WIDTH < DATA_WIDTH) begin : g_unused
    logic w_unused_hi;
    assign w_unused_hi = ^s_axis_data_tdata[DATA_WIDTH-1:VALUE_WIDTH];
  end

  assign w_value      = s_axis_data_tdata[VALUE_WIDTH-1:0];
  assign w_scanning   = (r_state == SCAN) && enable;
  assign w_scan_beat  = w_scanning && s_axis_data_tvalid;
  assign w_candidate  = w_scan_beat && (xk_in >= min_index) && (xk_in <= max_index)
                        && (w_value > threshold);
  // Strictly greater keeps the earliest bin on ties.
  assign w_take       = w_candidate && (!r_found || (w_value > r_peak_value));
  assign w_frame_done = w_scan_beat && s_axis_data_tlast;
  assign w_out_free   = !r_out_valid || m_axis_peak_tready;
  assign w_res_value  = w_take ? w_value : r_peak_value;
  assign w_res_index  = w_take ? xk_in : r_peak_index;
  assign w_res_found  = r_found || w_take;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (enable) w_state_next = SYNC;
      SYNC: begin
        if (!enable) w_state_next = IDLE;
        else if (s_axis_data_tvalid && s_axis_data_tlast) w_state_next = SCAN;
      end
      SCAN: if (!enable) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Running peak is wiped at frame close and whenever we are not actively scanning.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_peak_value <= '0;
      r_peak_index <= '0;
      r_found      <= 1'b0;
    end else if (w_frame_done || !w_scanning) begin
      r_peak_value <= '0;
      r_peak_index <= '0;
      r_found      <= 1'b0;
    end else if (w_take) begin
      r_peak_value <= w_value;
      r_peak_index <= xk_in;
      r_found      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_value   <= '0;
      r_out_index   <= '0;
      r_out_found   <= 1'b0;
      r_out_valid   <= 1'b0;
      r_frame_count <= '0;
      r_drop_count  <= '0;
    end else begin
      if (w_frame_done) r_frame_count <= r_frame_count + 1'b1;
      if (w_frame_done && w_out_free) begin
        r_out_value <= w_res_value;
        r_out_index <= w_res_index;
        r_out_found <= w_res_found;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && m_axis_peak_tready) begin
        r_out_valid <= 1'b0;
      end
      if (w_frame_done && !w_out_free) r_drop_count <= sat_inc(r_drop_count);
    end
  end

  assign s_axis_data_tready = 1'b1;
  assign m_axis_peak_tdata  = DATA_WIDTH'(r_out_value);
  assign m_axis_peak_tuser  = {r_out_found, r_out_index};
  assign m_axis_peak_tvalid = r_out_valid;
  assign frame_count        = r_frame_count;
  assign drop_count         = r_drop_count;

endmodule

// File: tb/tb_peak_detect.sv
// Directed stimulus with a queue-based scoreboard; a negedge monitor checks every delivered result.
module tb_peak_detect;
  localparam int VW = 24;
  localparam int IW = 10;

  typedef struct packed {
    logic [31:0] data;
    logic [IW:0] user;
  } res_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [IW-1:0] xk;
  logic          enable;
  logic [VW-1:0] threshold;
  logic [IW-1:0] min_index;
  logic [IW-1:0] max_index;
  logic [31:0]   m_tdata;
  logic [IW:0]   m_tuser;
  logic          m_tvalid;
  logic          m_tready;
  logic [15:0]   frame_count;
  logic [15:0]   drop_count;

  int   n_checks = 0;
  int   n_pass = 0;
  int   hs_count = 0;
  int   exp_hs = 0;
  int   exp_frames = 0;
  res_t exp_q[$];

  bit          hold_seen = 1'b0;
  logic [31:0] hold_data;
  logic [IW:0] hold_user;

  int f1[8]   = '{5, 9, 30, 7, 30, 2, 1, 4};
  int f2[8]   = '{1, 2, 3, 4, 5, 6, 7, 50};
  int fsync[8] = '{0, 100, 0, 0, 0, 0, 0, 0};

  peak_detect #(.VALUE_WIDTH(VW), .INDEX_WIDTH(IW)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tlast  (s_tlast),
    .s_axis_data_tready (s_tready),
    .xk_in              (xk),
    .enable             (enable),
    .threshold          (threshold),
    .min_index          (min_index),
    .max_index          (max_index),
    .m_axis_peak_tdata  (m_tdata),
    .m_axis_peak_tuser  (m_tuser),
    .m_axis_peak_tvalid (m_tvalid),
    .m_axis_peak_tready (m_tready),
    .frame_count        (frame_count),
    .drop_count         (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_res(input int v, input bit f, input int idx);
    exp_q.push_back({32'(v), f, IW'(idx)});
    exp_hs++;
  endtask

  // Monitor: result stability under backpressure and scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (!rstn) begin
      hold_seen = 1'b0;
    end else begin
      if (hold_seen && m_tvalid) begin
        check("hold_tdata", m_tdata, hold_data);
        check("hold_tuser", m_tuser, hold_user);
      end
      if (m_tvalid && m_tready) begin
        res_t e;
        hs_count++;
        check("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("result: tdata=%0d found=%0b index=%0d (want %0d/%0b/%0d)",
                   m_tdata, m_tuser[IW], m_tuser[IW-1:0], e.data, e.user[IW], e.user[IW-1:0]);
          check("result_tdata", m_tdata, e.data);
          check("result_tuser", m_tuser, e.user);
        end
      end
      hold_seen = m_tvalid && !m_tready;
      hold_data = m_tdata;
      hold_user = m_tuser;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int v, input int idx, input bit last);
    s_tdata  = 32'(v);
    xk       = IW'(idx);
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int vals[8]);
    for (int i = 0; i < 8; i++) drive(vals[i], i, i == 7);
  endtask

  task automatic resync(input int thr, input int lo, input int hi);
    enable = 1'b0;
    idle(2);
    threshold = VW'(thr);
    min_index = IW'(lo);
    max_index = IW'(hi);
    enable = 1'b1;
    idle(1);
    drive(0, 0, 1'b1);
  endtask

  initial begin
    rstn = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; xk = '0;
    enable = 1'b0; threshold = VW'(6); min_index = '0; max_index = IW'(1023); m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tuser", m_tuser, 0);
    check("rst_frames", frame_count, 0);
    check("rst_drops", drop_count, 0);
    check("rst_tready", s_tready, 1);
    rstn = 1'b1;
    idle(1);

    // Basic peak after one discarded sync frame
    enable = 1'b1;
    idle(1);
    send_frame(fsync);
    check("sync_no_frame", frame_count, 0);
    expect_res(30, 1, 2);
    send_frame(f1);
    exp_frames++;
    check("latency_tvalid", m_tvalid, 1);
    check("basic_frames", frame_count, 16'(exp_frames));
    idle(2);

    // Window, threshold, empty window, tlast-bin peak
    resync(6, 3, 5);
    expect_res(30, 1, 4);
    send_frame(f1); exp_frames++;
    idle(2);
    resync(40, 0, 1023);
    expect_res(0, 0, 0);
    send_frame(f1); exp_frames++;
    idle(2);
    resync(0, 5, 3);
    expect_res(0, 0, 0);
    send_frame(f1); exp_frames++;
    idle(2);
    resync(6, 0, 1023);
    expect_res(50, 1, 7);
    send_frame(f2); exp_frames++;
    idle(2);
    check("window_frames", frame_count, 16'(exp_frames));

    // Backpressure across three frames
    m_tready = 1'b0;
    expect_res(30, 1, 2);
    send_frame(f1);
    send_frame(f2);
    send_frame(f1);
    exp_frames += 3;
    idle(1);
    check("bp_drops", drop_count, 2);
    check("bp_frames", frame_count, 16'(exp_frames));
    check("bp_tvalid", m_tvalid, 1);
    check("bp_tdata", m_tdata, 30);
    m_tready = 1'b1;
    idle(1);
    check("bp_tvalid_clear", m_tvalid, 0);

    // Handshake coinciding with a new result
    expect_res(20, 1, 3);
    expect_res(15, 1, 9);
    drive(20, 3, 1'b1);
    drive(15, 9, 1'b1);
    exp_frames += 2;
    check("simul_tvalid", m_tvalid, 1);
    check("simul_drops", drop_count, 2);
    idle(2);
    check("simul_tvalid_clear", m_tvalid, 0);

    // Disable at bin 3 discards the frame; next full frame is a sync frame
    drive(3, 0, 1'b0); drive(100, 1, 1'b0); drive(4, 2, 1'b0);
    enable = 1'b0;
    drive(9, 3, 1'b0); drive(1, 4, 1'b0); drive(1, 5, 1'b0); drive(1, 6, 1'b0); drive(8, 7, 1'b1);
    idle(1);
    check("dis_tvalid", m_tvalid, 0);
    check("dis_frames", frame_count, 16'(exp_frames));
    enable = 1'b1;
    idle(1);
    send_frame(fsync);
    check("dis_sync_frames", frame_count, 16'(exp_frames));
    expect_res(30, 1, 2);
    send_frame(f1); exp_frames++;
    idle(2);
    check("dis_after_frames", frame_count, 16'(exp_frames));

    // Reset at bin 3 while a result is held
    m_tready = 1'b0;
    send_frame(f1);
    drive(3, 0, 1'b0); drive(100, 1, 1'b0); drive(4, 2, 1'b0);
    rstn = 1'b0;
    #2;
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_tdata", m_tdata, 0);
    check("mid_rst_tuser", m_tuser, 0);
    check("mid_rst_frames", frame_count, 0);
    check("mid_rst_drops", drop_count, 0);
    check("mid_rst_tready", s_tready, 1);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    send_frame(fsync);
    m_tready = 1'b1;
    expect_res(30, 1, 2);
    send_frame(f1);
    exp_frames = 1;
    idle(2);
    check("post_rst_frames", frame_count, 16'(exp_frames));
    check("post_rst_drops", drop_count, 0);

    // Counter saturation and wrap with single-beat frames
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    idle(1);
    drive(0, 0, 1'b1);
    m_tready = 1'b0;
    expect_res(10, 1, 0);
    for (int i = 1; i <= 65538; i++) begin
      drive(10, 0, 1'b1);
      if (i == 65535) check("drop_fffe", drop_count, 16'hFFFE);
      if (i == 65536) begin
        check("drop_sat", drop_count, 16'hFFFF);
        check("frame_wrap", frame_count, 0);
      end
    end
    check("drop_stays_sat", drop_count, 16'hFFFF);
    check("frame_after_wrap", frame_count, 2);
    m_tready = 1'b1;
    idle(2);
    check("final_tvalid", m_tvalid, 0);

    check("queue_empty", exp_q.size(), 0);
    check("handshakes", hs_count, exp_hs);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
